// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the write-arbiter state type.
package fb_pkg;
  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int COLOUR_W = 6;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 15;

  typedef enum logic {IDLE, CLEAR} fb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible request at or after ptr_i,
// where a request is eligible if it is set in req_i and not set in mask_i.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  input  logic [N_REQ-1:0]         mask_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] eligible;
  assign eligible = req_i & ~mask_i;

  always_comb begin : pick
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_o && eligible[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Round-robin framebuffer write-port arbiter with a clear-screen sequencer.
// Optional macro FB_VBLANK_WRITE_EN restricts all writes to vertical blanking.
module framebuffer_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int H_RES    = fb_pkg::H_RES,
  parameter int V_RES    = fb_pkg::V_RES,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int COLOUR_W = fb_pkg::COLOUR_W
) (
  input  logic                      vga_clock,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*X_W-1:0]      req_x,
  input  logic [N_REQ*Y_W-1:0]      req_y,
  input  logic [N_REQ*COLOUR_W-1:0] req_colour,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      clear_start,
  input  logic [COLOUR_W-1:0]       clear_colour,
  input  logic                      in_vblank,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [COLOUR_W-1:0]       mem_data,
  output logic                      mem_we,
  output logic                      busy,
  output logic                      clear_done,
  output logic                      oob_drop
);
  import fb_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int DEPTH = H_RES * V_RES;

  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return ADDR_W'(ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x));
  endfunction

  fb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [COLOUR_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                we_q, we_d, busy_q, busy_d, done_q, done_d, oob_q, oob_d;

  logic [N_REQ-1:0]    grant;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_c;
  logic                vb_ok;

`ifdef FB_VBLANK_WRITE_EN
  assign vb_ok = in_vblank;
`else
  // Writes are unconstrained; in_vblank is referenced only to keep the port live.
  assign vb_ok = in_vblank | 1'b1;
`endif

  // Last cycle's grant is exactly the registered ready vector.
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .mask_i  (ready_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (win_any)
  );

  assign sel_x = req_x[win_idx*X_W +: X_W];
  assign sel_y = req_y[win_idx*Y_W +: Y_W];
  assign sel_c = req_colour[win_idx*COLOUR_W +: COLOUR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    ptr_d   = ptr_q;
    ready_d = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    oob_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fill_d  = clear_colour;
          busy_d  = 1'b1;
        end else if (win_any && vb_ok) begin
          ready_d = grant;
          ptr_d   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
          if (32'(sel_x) >= H_RES || 32'(sel_y) >= V_RES) begin
            oob_d = 1'b1;
          end else begin
            we_d   = 1'b1;
            addr_d = xy_to_addr(sel_x, sel_y);
            data_d = sel_c;
          end
        end
      end
      CLEAR: begin
        if (vb_ok) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = fill_q;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
      ready_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
    end
  end

  assign req_ready  = ready_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_we     = we_q;
  assign busy       = busy_q;
  assign clear_done = done_q;
  assign oob_drop   = oob_q;
endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// Directed self-checking bench for framebuffer_write_arbiter (default build).
module tb_framebuffer_write_arbiter;
  localparam int N = 4, XW = 8, YW = 7, AW = 15, CW = 6, DEPTH = 19200;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req_valid;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*CW-1:0] req_colour;
  logic [N-1:0]  req_ready;
  logic          clear_start;
  logic [CW-1:0] clear_colour;
  logic          in_vblank;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data;
  logic          mem_we, busy, clear_done, oob_drop;

  int checks = 0;
  int errors = 0;

  framebuffer_write_arbiter dut (
    .vga_clock    (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_colour   (req_colour),
    .req_ready    (req_ready),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .in_vblank    (in_vblank),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .busy         (busy),
    .clear_done   (clear_done),
    .oob_drop     (oob_drop)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_client(input int i, input int x, input int y, input int c);
    req_x[i*XW +: XW]      = XW'(x);
    req_y[i*YW +: YW]      = YW'(y);
    req_colour[i*CW +: CW] = CW'(c);
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_colour = '0;
    clear_start = 1'b0; clear_colour = '0; in_vblank = 1'b1;
    tick(); tick();
    checks++;
    if ({req_ready, mem_we, busy, clear_done, oob_drop} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000000", {req_ready, mem_we, busy, clear_done, oob_drop});
    end
    checks++;
    if (mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d data=%h expected 0/0", mem_addr, mem_data);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_client(0, 3, 2, 'h2A);
    req_valid = 4'b0001;
    tick();
    checks++;
    if (req_ready !== 4'b0001 || mem_we !== 1'b1 || mem_addr !== 15'd323 || mem_data !== 6'h2A) begin
      errors++;
      $display("FAIL single_write got rdy=%b we=%b addr=%0d data=%h expected 0001/1/323/2a",
               req_ready, mem_we, mem_addr, mem_data);
    end
    req_valid = '0;
    tick();
    checks++;
    if (req_ready !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 15'd323 || mem_data !== 6'h2A) begin
      errors++;
      $display("FAIL idle_hold got rdy=%b we=%b addr=%0d data=%h expected 0000/0/323/2a",
               req_ready, mem_we, mem_addr, mem_data);
    end
  endtask

  task automatic test_round_robin();
    int order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) set_client(i, i, i, i + 1);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (req_ready !== (4'b0001 << order[c]) || mem_we !== 1'b1 ||
          mem_addr !== AW'(order[c] * 161) || mem_data !== CW'(order[c] + 1)) begin
        errors++;
        $display("FAIL rr_cycle%0d got rdy=%b we=%b addr=%0d data=%h expected client %0d addr %0d",
                 c, req_ready, mem_we, mem_addr, mem_data, order[c], order[c] * 161);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_rdy [3] = '{4'b0100, 4'b0000, 4'b0100};
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (req_ready !== exp_rdy[c] || mem_we !== exp_rdy[c][2]) begin
        errors++;
        $display("FAIL b2b_cycle%0d got rdy=%b we=%b expected rdy=%b", c, req_ready, mem_we, exp_rdy[c]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_oob();
    set_client(3, 160, 5, 'h11);
    req_valid = 4'b1000;
    tick();
    checks++;
    if (req_ready !== 4'b1000 || mem_we !== 1'b0 || oob_drop !== 1'b1 || mem_addr !== 15'd322) begin
      errors++;
      $display("FAIL oob_x got rdy=%b we=%b oob=%b addr=%0d expected 1000/0/1/322",
               req_ready, mem_we, oob_drop, mem_addr);
    end
    req_valid = '0;
    tick();
    checks++;
    if (oob_drop !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL oob_pulse got oob=%b rdy=%b expected 0/0000", oob_drop, req_ready);
    end
    set_client(0, 0, 120, 'h05);
    req_valid = 4'b0001;
    tick();
    checks++;
    if (req_ready !== 4'b0001 || mem_we !== 1'b0 || oob_drop !== 1'b1) begin
      errors++;
      $display("FAIL oob_y got rdy=%b we=%b oob=%b expected 0001/0/1", req_ready, mem_we, oob_drop);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_clear();
    int bad = 0;
    int writes = 0;
    set_client(1, 10, 10, 'h15);
    req_valid = 4'b0010;
    clear_start = 1'b1; clear_colour = 6'h00;
    tick();
    clear_start = 1'b0; clear_colour = 6'h3F;
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_entry got rdy=%b busy=%b we=%b expected 0000/1/0", req_ready, busy, mem_we);
    end
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      if (k == 100) clear_start = 1'b1;
      if (k == 101) clear_start = 1'b0;
      if (mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_data !== 6'h00 || req_ready !== 4'b0000) bad++;
      if (clear_done !== (k == DEPTH - 1) || busy !== (k != DEPTH - 1)) bad++;
      if (mem_we === 1'b1) writes++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sequence got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (writes != DEPTH) begin
      errors++;
      $display("FAIL clear_count got %0d expected %0d", writes, DEPTH);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0010 || mem_we !== 1'b1 || mem_addr !== 15'd1610 ||
        mem_data !== 6'h15 || busy !== 1'b0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL after_clear got rdy=%b we=%b addr=%0d data=%h busy=%b done=%b expected 0010/1/1610/15/0/0",
               req_ready, mem_we, mem_addr, mem_data, busy, clear_done);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    int bad = 0;
    clear_start = 1'b1; clear_colour = 6'h2A;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 6000 && !found; k++) begin
      tick();
      if (mem_we === 1'b1 && mem_addr === 15'd5000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_5000 got addr=%0d expected 5000 within bound", mem_addr);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({req_ready, mem_we, busy, clear_done, oob_drop} !== 8'h00 || mem_addr !== '0 || mem_data !== '0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%b addr=%0d data=%h expected all zero",
               {req_ready, mem_we, busy, clear_done, oob_drop}, mem_addr, mem_data);
    end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy !== 1'b0 || clear_done !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_oob();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
